// File: rtl/pr_bus_arbiter_if.sv
// Processor-bus bundle between two masters, the arbiter and two timer devices.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests and device read data (masters, devices, bench).
interface pr_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_gnt;
    logic        m0_err;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_gnt;
    logic        m1_err;
    logic [31:0] m_rd;
    logic [31:0] dev_addr;
    logic [31:0] dev_wd;
    logic        dev0_we;
    logic        dev1_we;
    logic [31:0] dev0_rd;
    logic [31:0] dev1_rd;
    logic        busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        input  m1_req, m1_we, m1_addr, m1_wd,
        input  dev0_rd, dev1_rd,
        output m0_gnt, m0_err, m1_gnt, m1_err, m_rd,
        output dev_addr, dev_wd, dev0_we, dev1_we, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        output m1_req, m1_we, m1_addr, m1_wd,
        output dev0_rd, dev1_rd,
        input  m0_gnt, m0_err, m1_gnt, m1_err, m_rd,
        input  dev_addr, dev_wd, dev0_we, dev1_we, busy
    );
endinterface

// File: rtl/pr_bus_arbiter.sv
// Two-master processor-bus arbiter with round-robin grant and address decode
// for two word-addressed timer devices. Every transaction takes exactly three
// cycles (IDLE -> ACCESS -> RESP); illegal accesses complete with an error and
// never strobe a device.
module pr_bus_arbiter #(
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
    parameter logic [31:0] DEV_SPAN  = 32'd12,
    parameter logic [31:0] RO_OFFSET = 32'd8
) (
    input logic              clk,
    input logic              reset,
    pr_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Address decode: returns {illegal, hit1, hit0}. The read-only COUNT
    // register is only illegal for writes; reads of it are normal.
    function automatic logic [2:0] decode(input logic [31:0] addr, input logic we);
        logic hit0;
        logic hit1;
        logic aligned;
        logic ro_write;
        hit0     = (addr >= DEV0_BASE) && (addr < (DEV0_BASE + DEV_SPAN));
        hit1     = (addr >= DEV1_BASE) && (addr < (DEV1_BASE + DEV_SPAN));
        aligned  = (addr[1:0] == 2'b00);
        ro_write = we && ((hit0 && ((addr - DEV0_BASE) == RO_OFFSET)) ||
                          (hit1 && ((addr - DEV1_BASE) == RO_OFFSET)));
        return {(!aligned) || !(hit0 || hit1) || ro_write, hit1, hit0};
    endfunction

    state_t      state_r;
    logic        owner_r;
    logic        last_owner_r;
    logic        we_r;
    logic        illegal_r;
    logic        hit0_r;

    logic        pick_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wd_s;
    logic        sel_we_s;
    logic [2:0]  sel_dec_s;

    // Round-robin owner selection and decode of the candidate request.
    always_comb begin
        pick_s = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            pick_s = ~last_owner_r;
        end else if (bus.m1_req) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        sel_addr_s = pick_s ? bus.m1_addr : bus.m0_addr;
        sel_wd_s   = pick_s ? bus.m1_wd   : bus.m0_wd;
        sel_we_s   = pick_s ? bus.m1_we   : bus.m0_we;
        sel_dec_s  = decode(sel_addr_s, sel_we_s);
    end

    // Transaction sequencer; all bus-facing outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            we_r         <= 1'b0;
            illegal_r    <= 1'b0;
            hit0_r       <= 1'b0;
            bus.m0_gnt   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m1_gnt   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m_rd     <= 32'h0000_0000;
            bus.dev_addr <= 32'h0000_0000;
            bus.dev_wd   <= 32'h0000_0000;
            bus.dev0_we  <= 1'b0;
            bus.dev1_we  <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.m0_gnt <= 1'b0;
                    bus.m0_err <= 1'b0;
                    bus.m1_gnt <= 1'b0;
                    bus.m1_err <= 1'b0;
                    bus.m_rd   <= 32'h0000_0000;
                    if (bus.m0_req || bus.m1_req) begin
                        owner_r      <= pick_s;
                        bus.dev_addr <= sel_addr_s;
                        bus.dev_wd   <= sel_wd_s;
                        we_r         <= sel_we_s;
                        illegal_r    <= sel_dec_s[2];
                        hit0_r       <= sel_dec_s[0];
                        // The strobe is set here so it is high for exactly the ACCESS cycle.
                        bus.dev0_we  <= sel_we_s & sel_dec_s[0] & ~sel_dec_s[2];
                        bus.dev1_we  <= sel_we_s & sel_dec_s[1] & ~sel_dec_s[2];
                        bus.busy     <= 1'b1;
                        state_r      <= ACCESS;
                    end else begin
                        bus.dev0_we  <= 1'b0;
                        bus.dev1_we  <= 1'b0;
                        bus.busy     <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                ACCESS: begin
                    bus.dev0_we  <= 1'b0;
                    bus.dev1_we  <= 1'b0;
                    last_owner_r <= owner_r;
                    if (illegal_r || we_r) begin
                        bus.m_rd <= 32'h0000_0000;
                    end else begin
                        bus.m_rd <= hit0_r ? bus.dev0_rd : bus.dev1_rd;
                    end
                    bus.m0_gnt   <= ~owner_r;
                    bus.m1_gnt   <= owner_r;
                    bus.m0_err   <= ~owner_r & illegal_r;
                    bus.m1_err   <= owner_r & illegal_r;
                    bus.busy     <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    bus.m0_gnt  <= 1'b0;
                    bus.m0_err  <= 1'b0;
                    bus.m1_gnt  <= 1'b0;
                    bus.m1_err  <= 1'b0;
                    bus.m_rd    <= 32'h0000_0000;
                    bus.dev0_we <= 1'b0;
                    bus.dev1_we <= 1'b0;
                    bus.busy    <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    bus.m0_gnt  <= 1'b0;
                    bus.m0_err  <= 1'b0;
                    bus.m1_gnt  <= 1'b0;
                    bus.m1_err  <= 1'b0;
                    bus.m_rd    <= 32'h0000_0000;
                    bus.dev0_we <= 1'b0;
                    bus.dev1_we <= 1'b0;
                    bus.busy    <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Self-checking bench for pr_bus_arbiter: directed scenarios followed by
// randomized traffic, checked cycle by cycle against a transaction-level model.
module tb_pr_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // Model state: who won the previous arbitration (1 after reset).
    int          last_w = 1;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        w [2];

    pr_bus_arbiter_if bus ();

    pr_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: which device (or -1) and whether the access is illegal.
    function automatic void model(input logic [31:0] addr, input logic we,
                                  output int dev, output bit ill);
        logic [31:0] off;
        dev = -1;
        off = 32'd0;
        if (addr >= 32'h7F00 && addr < 32'h7F0C) begin
            dev = 0;
            off = addr - 32'h7F00;
        end else if (addr >= 32'h7F10 && addr < 32'h7F1C) begin
            dev = 1;
            off = addr - 32'h7F10;
        end
        ill = ((addr & 32'd3) != 32'd0) || (dev < 0) || (we && off == 32'd8);
    endfunction

    task automatic drive(input int m, input logic [31:0] addr, input logic we, input logic [31:0] wd);
        a[m] = addr; w[m] = we; d[m] = wd;
        if (m == 0) begin
            bus.m0_addr = addr; bus.m0_we = we; bus.m0_wd = wd; bus.m0_req = 1'b1;
        end else begin
            bus.m1_addr = addr; bus.m1_we = we; bus.m1_wd = wd; bus.m1_req = 1'b1;
        end
    endtask

    // One full transaction, entered at an IDLE-cycle negedge with requests set.
    task automatic serve();
        int          wn;
        int          dev;
        bit          ill;
        logic [31:0] exp_rd;
        if (bus.m0_req && bus.m1_req) wn = (last_w == 1) ? 0 : 1;
        else wn = bus.m1_req ? 1 : 0;
        model(a[wn], w[wn], dev, ill);
        exp_rd = (ill || w[wn]) ? 32'd0 : ((dev == 0) ? bus.dev0_rd : bus.dev1_rd);
        chk("idle_busy", bus.busy, 32'd0);
        @(negedge clk);
        chk("acc_dev0_we", bus.dev0_we, w[wn] && dev == 0 && !ill);
        chk("acc_dev1_we", bus.dev1_we, w[wn] && dev == 1 && !ill);
        chk("acc_dev_addr", bus.dev_addr, a[wn]);
        chk("acc_dev_wd", bus.dev_wd, d[wn]);
        chk("acc_busy", bus.busy, 32'd1);
        chk("acc_gnt", {bus.m1_gnt, bus.m0_gnt}, 32'd0);
        @(negedge clk);
        chk("resp_m0_gnt", bus.m0_gnt, wn == 0);
        chk("resp_m1_gnt", bus.m1_gnt, wn == 1);
        chk("resp_m0_err", bus.m0_err, wn == 0 && ill);
        chk("resp_m1_err", bus.m1_err, wn == 1 && ill);
        chk("resp_m_rd", bus.m_rd, exp_rd);
        chk("resp_dev_we", {bus.dev1_we, bus.dev0_we}, 32'd0);
        chk("resp_busy", bus.busy, 32'd1);
        last_w = wn;
        if (wn == 0) bus.m0_req = 1'b0;
        else bus.m1_req = 1'b0;
        @(negedge clk);
        chk("idle_gnt", {bus.m1_gnt, bus.m0_gnt}, 32'd0);
        chk("idle_err", {bus.m1_err, bus.m0_err}, 32'd0);
        chk("idle_m_rd", bus.m_rd, 32'd0);
        chk("idle_dev_we", {bus.dev1_we, bus.dev0_we}, 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && (bus.m0_req || bus.m1_req); k++) serve();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h7F00 + 32'd4 * $urandom_range(0, 8);
            1:       return 32'h7EF8 + $urandom_range(0, 47);
            2:       return $urandom();
            default: return 32'h7F10 + 32'd4 * $urandom_range(0, 2);
        endcase
    endfunction

    initial begin
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'd0; bus.m0_wd = 32'd0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'd0; bus.m1_wd = 32'd0;
        bus.dev0_rd = 32'hA5A5_0000;
        bus.dev1_rd = 32'h1234_5678;

        // Reset state
        #12;
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_gnt", {bus.m1_gnt, bus.m0_gnt}, 32'd0);
        chk("rst_err", {bus.m1_err, bus.m0_err}, 32'd0);
        chk("rst_m_rd", bus.m_rd, 32'd0);
        chk("rst_dev_addr", bus.dev_addr, 32'd0);
        chk("rst_dev_wd", bus.dev_wd, 32'd0);
        chk("rst_dev_we", {bus.dev1_we, bus.dev0_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: m0 write to timer 0
        drive(0, 32'h7F04, 1'b1, 32'h0000_00FF);
        serve();
        // 2: m1 read of timer 1
        drive(1, 32'h7F18, 1'b0, 32'h0);
        serve();
        // 3: both requesting continuously, strict alternation
        drive(0, 32'h7F00, 1'b0, 32'h0);
        drive(1, 32'h7F14, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            serve();
            if (last_w == 0) drive(0, 32'h7F00, 1'b0, 32'h0);
            else drive(1, 32'h7F14, 1'b0, 32'h0);
        end
        drain();
        // 4: unmapped and unaligned writes
        drive(0, 32'h7F20, 1'b1, 32'h1111_1111);
        serve();
        drive(0, 32'h7F02, 1'b1, 32'h2222_2222);
        serve();
        // 5: write to read-only COUNT, then a legal read of it
        drive(1, 32'h7F08, 1'b1, 32'h0000_DEAD);
        serve();
        drive(1, 32'h7F08, 1'b0, 32'h0);
        serve();

        // 6: reset during ACCESS of an m0 write
        drive(0, 32'h7F00, 1'b1, 32'hCAFE_F00D);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_dev0_we", bus.dev0_we, 32'd0);
        chk("arst_busy", bus.busy, 32'd0);
        chk("arst_dev_addr", bus.dev_addr, 32'd0);
        chk("arst_dev_wd", bus.dev_wd, 32'd0);
        @(negedge clk);
        chk("arst_no_gnt", {bus.m1_gnt, bus.m0_gnt}, 32'd0);
        last_w = 1;
        drive(0, 32'h7F04, 1'b0, 32'h0);
        drive(1, 32'h7F10, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drain();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            bus.dev0_rd = $urandom();
            bus.dev1_rd = $urandom();
            if (pat[0]) drive(0, rand_addr(), 1'($urandom_range(0, 1)), $urandom());
            if (pat[1]) drive(1, rand_addr(), 1'($urandom_range(0, 1)), $urandom());
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
